wb_block_copy_master: RTL

WB_BLOCK_COPY_MASTER -- requirements
Module: wb_block_copy_master

---
 rtl/wb_block_copy_master.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/wb_block_copy_master.sv
// Wishbone block-copy master: moves len words from src to dst through an 8-word buffer.
// Define WB_INCR_BURST_EN for incrementing bursts; default build issues classic cycles.
module wb_block_copy_master #(
    parameter int Dw     = 32,
    parameter int Aw     = 10,
    parameter int SELw   = Dw/8,
    parameter int CTIw   = 3,
    parameter int BTEw   = 2,
    parameter int BUF_Aw = 3,
    parameter int LENw   = Aw+1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [Aw-1:0]   src_addr,
    input  logic [Aw-1:0]   dst_addr,
    input  logic [LENw-1:0] len,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [Dw-1:0]   m_dat_o,
    output logic [SELw-1:0] m_sel_o,
    output logic [Aw-1:0]   m_addr_o,
    output logic [CTIw-1:0] m_cti_o,
    output logic [BTEw-1:0] m_bte_o,
    output logic            m_stb_o,
    output logic            m_cyc_o,
    output logic            m_we_o,
    input  logic [Dw-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            m_err_i,
    input  logic            m_rty_i
);
    localparam int CHUNK_W = BUF_Aw + 1;
    localparam int BUF_DEPTH = 2**BUF_Aw;
    localparam logic [CHUNK_W-1:0] IDX_ONE    = CHUNK_W'(1);
    localparam logic [CHUNK_W-1:0] CHUNK_FULL = CHUNK_W'(BUF_DEPTH);
    localparam logic [LENw-1:0]    LEN_FULL   = LENw'(BUF_DEPTH);
    localparam logic [LENw-1:0]    REM_ONE    = LENw'(1);
    localparam logic [Aw-1:0]      A_ONE      = Aw'(1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t               state_q;
    logic [Aw-1:0]        rd_addr_q, wr_addr_q, addr_q;
    logic [LENw-1:0]      rem_q;
    logic [CHUNK_W-1:0]   idx_q, chunk_q;
    logic [Dw-1:0]        dat_q;
    logic [SELw-1:0]      sel_q;
    logic [CTIw-1:0]      cti_q;
    logic                 cyc_q, stb_q, we_q, busy_q, done_q, error_q;
    logic [Dw-1:0]        buf_mem [BUF_DEPTH];

    logic                 beat_err, beat_ack, last_beat, buf_we;
    logic [CHUNK_W-1:0]   idx_nxt;
    logic [CTIw-1:0]      launch_cti;

    function automatic logic [CHUNK_W-1:0] chunk_of(input logic [LENw-1:0] n);
        return (n > LEN_FULL) ? CHUNK_FULL : n[CHUNK_W-1:0];
    endfunction

`ifdef WB_INCR_BURST_EN
    localparam logic [CTIw-1:0] CTI_INCR = CTIw'(3'b010);
    localparam logic [CTIw-1:0] CTI_EOB  = CTIw'(3'b111);

    function automatic logic [CTIw-1:0] cti_for(input logic [CHUNK_W-1:0] idx,
                                                input logic [CHUNK_W-1:0] chunk);
        return (idx + IDX_ONE == chunk) ? CTI_EOB : CTI_INCR;
    endfunction

    assign launch_cti = cti_for(idx_q, chunk_q);
`else
    assign launch_cti = '0;
`endif

    // err wins over ack; rty leaves the beat pending so it is simply re-presented
    assign beat_err  = stb_q & m_err_i;
    assign beat_ack  = stb_q & ~m_err_i & ~m_rty_i & m_ack_i;
    assign idx_nxt   = idx_q + IDX_ONE;
    assign last_beat = (idx_nxt == chunk_q);
    assign buf_we    = (state_q == READ) & beat_ack;

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[idx_q[BUF_Aw-1:0]] <= m_dat_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            chunk_q   <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            cti_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_addr_q <= src_addr;
                        wr_addr_q <= dst_addr;
                        rem_q     <= len;
                        idx_q     <= '0;
                        chunk_q   <= chunk_of(len);
                        error_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        if (len != '0) begin
                            state_q <= READ;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ, WRITE: begin
                    if (!stb_q) begin
                        cyc_q  <= 1'b1;
                        stb_q  <= 1'b1;
                        sel_q  <= '1;
                        we_q   <= (state_q == WRITE);
                        addr_q <= (state_q == WRITE) ? wr_addr_q : rd_addr_q;
                        dat_q  <= (state_q == WRITE) ? buf_mem[idx_q[BUF_Aw-1:0]] : '0;
                        cti_q  <= launch_cti;
                    end else if (beat_err) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= '0;
                        cti_q   <= '0;
                        error_q <= 1'b1;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (beat_ack) begin
                        idx_q <= idx_nxt;
                        if (state_q == READ) begin
                            rd_addr_q <= rd_addr_q + A_ONE;
                        end else begin
                            wr_addr_q <= wr_addr_q + A_ONE;
                            rem_q     <= rem_q - REM_ONE;
                        end
                        if (last_beat) begin
                            // dropping cyc here yields the single idle cycle between phases
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            we_q  <= 1'b0;
                            sel_q <= '0;
                            cti_q <= '0;
                            idx_q <= '0;
                            if (state_q == READ) begin
                                state_q <= WRITE;
                            end else if (rem_q == REM_ONE) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= READ;
                                chunk_q <= chunk_of(rem_q - REM_ONE);
                            end
                        end else begin
`ifdef WB_INCR_BURST_EN
                            addr_q <= addr_q + A_ONE;
                            dat_q  <= (state_q == WRITE) ? buf_mem[idx_nxt[BUF_Aw-1:0]] : '0;
                            cti_q  <= cti_for(idx_nxt, chunk_q);
`else
                            stb_q <= 1'b0;
`endif
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign m_dat_o  = dat_q;
    assign m_sel_o  = sel_q;
    assign m_addr_o = addr_q;
    assign m_cti_o  = cti_q;
    assign m_bte_o  = '0;
    assign m_stb_o  = stb_q;
    assign m_cyc_o  = cyc_q;
    assign m_we_o   = we_q;
endmodule
